// File: rtl/mdio_c45_master.sv
// mdio_c45_master: Wishbone-controlled Clause-45 MDIO master issuing one frame per START command.
module mdio_c45_master #(
  parameter int CLK_DIV = 20,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        mdc,
  input  logic        mdi,
  output logic        mdo,
  output logic        mdo_oe,
  output logic        mdio_sel
);
  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, END} state_t;
  state_t state, state_n;
  logic [5:0] bcnt, bcnt_n;
  logic [7:0] div;
  logic tick, rise, fall, acc, wr, ctrl_start, start, bad_start, busy;
  logic [1:0] op;
  logic port, valid, noresp, rd, unused_ok;
  logic [4:0] prtad, devad;
  logic [15:0] wdata, rdata, rsh;
  logic [31:0] tx, rmux;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[30:16]};
  assign busy = state != IDLE;
  assign tick = div == 8'(CLK_DIV - 1);
  assign rise = busy & tick & ~mdc;
  assign fall = busy & tick & mdc;
  // registered ack/err gate the strobe so a held strobe is not taken twice
  assign acc = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign wr = acc & wb_we_i;
  assign ctrl_start = wr & (wb_adr_i[3:2] == 2'd0) & wb_dat_i[31];
  assign start = ctrl_start & ~busy;
  assign bad_start = ctrl_start & busy;
  assign mdo = (state == HDR || state == TA || state == DATA) ? tx[31] : 1'b1;
  assign mdo_oe = state == PRE || state == HDR || ((state == TA || state == DATA) && !rd);
  assign rmux = wb_adr_i[3:2] == 2'd0 ? {busy, noresp, 27'd0, port, op} :
                wb_adr_i[3:2] == 2'd1 ? {19'd0, devad, 3'd0, prtad} :
                wb_adr_i[3:2] == 2'd2 ? {16'd0, wdata} : {15'd0, valid, rdata};
  always_comb begin
    state_n = state;
    bcnt_n = bcnt;
    if (state == IDLE) begin
      if (start) begin
        state_n = PREAMBLE_LEN > 0 ? PRE : HDR;
        bcnt_n = PREAMBLE_LEN > 0 ? 6'(PREAMBLE_LEN - 1) : 6'd13;
      end
    end else if (fall) begin
      if (bcnt != 6'd0) bcnt_n = bcnt - 6'd1;
      else
        case (state)
          PRE: begin state_n = HDR; bcnt_n = 6'd13; end
          HDR: begin state_n = TA; bcnt_n = 6'd1; end
          TA: begin state_n = DATA; bcnt_n = 6'd15; end
          DATA: begin state_n = END; bcnt_n = 6'd0; end
          default: begin state_n = IDLE; bcnt_n = 6'd0; end
        endcase
    end
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      bcnt <= '0;
    end else begin
      state <= state_n;
      bcnt <= bcnt_n;
    end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      div <= '0;
      mdc <= 1'b0;
      mdio_sel <= 1'b0;
      op <= '0;
      port <= 1'b0;
      prtad <= '0;
      devad <= '0;
      wdata <= '0;
      rdata <= '0;
      rsh <= '0;
      valid <= 1'b0;
      noresp <= 1'b0;
      rd <= 1'b0;
      tx <= '0;
    end else begin
      wb_ack_o <= acc & ~bad_start;
      wb_err_o <= bad_start;
      wb_dat_o <= acc ? rmux : 32'd0;
      div <= (!busy || tick) ? 8'd0 : div + 8'd1;
      mdc <= busy & (tick ? ~mdc : mdc);
      if (wr && !busy && wb_adr_i[3:2] == 2'd0) begin
        op <= wb_dat_i[1:0];
        port <= wb_dat_i[2];
      end
      if (wr && !busy && wb_adr_i[3:2] == 2'd1) begin
        prtad <= wb_dat_i[4:0];
        devad <= wb_dat_i[12:8];
      end
      if (wr && !busy && wb_adr_i[3:2] == 2'd2) wdata <= wb_dat_i[15:0];
      // the frame shadow: header, turnaround and data shifted out MSB first
      if (start) begin
        tx <= {2'b00, wb_dat_i[1:0], prtad, devad, 2'b10, wdata};
        rd <= wb_dat_i[1];
        mdio_sel <= wb_dat_i[2];
        valid <= 1'b0;
        noresp <= 1'b0;
      end else if (fall && (state == HDR || state == TA || state == DATA))
        tx <= {tx[30:0], 1'b0};
      if (rise && rd && state == TA && bcnt == 6'd0) noresp <= mdi;
      if (rise && state == DATA) rsh <= {rsh[14:0], mdi};
      if (fall && rd && state == DATA && bcnt == 6'd0) begin
        rdata <= rsh;
        valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mdio_c45_master.sv
// tb_mdio_c45_master: directed frames against a default instance and a fast CLK_DIV=2, no-preamble instance.
module tb_mdio_c45_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cyc = 1'b0, we = 1'b0;
  logic [1:0] stb = 2'b00;
  logic [31:0] adr = '0, dat = '0, dat0, dat1;
  logic ack0, ack1, err0, err1, mdc0, mdc1, mdo0, mdo1, oe0, oe1, sel0, sel1, mdi0;
  int total = 0, bad = 0, cycles = 0, nr = 0, base = 0, tlast0 = 0, tlast1 = 0, tack = 0;
  logic [127:0] hist = '0, ohist = '0;
  logic phy = 1'b0;
  logic [15:0] pdata = '0;
  logic [3:0] pi;

  always #5 clk = ~clk;
  always @(posedge clk) cycles++;
  always @(posedge mdc0) begin
    nr++;
    hist = {hist[126:0], mdo0};
    ohist = {ohist[126:0], oe0};
  end
  always @(negedge mdc0) tlast0 = cycles;
  always @(negedge mdc1) tlast1 = cycles;

  // PHY: TA second bit driven 0, then pdata MSB first; otherwise the line floats high
  assign pi = 4'(63 - (nr - base));
  assign mdi0 = !phy ? 1'b1 : (nr - base == 47) ? 1'b0 :
                (nr - base >= 48 && nr - base <= 63) ? pdata[pi] : 1'b1;

  mdio_c45_master u0 (.wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb[0]), .wb_we_i(we),
    .wb_sel_i(4'hF), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0),
    .mdc(mdc0), .mdi(mdi0), .mdo(mdo0), .mdo_oe(oe0), .mdio_sel(sel0));
  mdio_c45_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) u1 (.wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc),
    .wb_stb_i(stb[1]), .wb_we_i(we), .wb_sel_i(4'hF), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat1),
    .wb_ack_o(ack1), .wb_err_o(err1), .mdc(mdc1), .mdi(1'b1), .mdo(mdo1), .mdo_oe(oe1), .mdio_sel(sel1));

  task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task wb(input int d, input logic w, input logic [31:0] a, input logic [31:0] v,
          output logic [31:0] q, output logic k, output logic e, output int n);
    cyc = 1'b1;
    stb = d != 0 ? 2'b10 : 2'b01;
    we = w;
    adr = a;
    dat = v;
    q = '0;
    k = 1'b0;
    e = 1'b0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (d != 0 ? (ack1 | err1) : (ack0 | err0)) begin
        n = i;
        k = d != 0 ? ack1 : ack0;
        e = d != 0 ? err1 : err0;
        q = d != 0 ? dat1 : dat0;
        tack = cycles;
        break;
      end
    end
    cyc = 1'b0;
    stb = 2'b00;
    we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task wait_done(input int d, output logic [31:0] q);
    logic k, e;
    int n;
    q = 32'hFFFF_FFFF;
    for (int i = 0; i < 2000; i++) begin
      wb(d, 1'b0, 32'h0, 32'h0, q, k, e, n);
      if (n != 0 && !q[31]) break;
    end
  endtask

  initial begin
    logic [31:0] q;
    logic k, e;
    int n, t0;
    #1 rst = 1'b1;
    #2;
    chk("rst_mdo", mdo0, 1);
    chk("rst_oe_mdc_sel", {oe0, mdc0, sel0}, 0);
    chk("rst_ack_err_dat", {ack0, err0, dat0}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wb(0, 1'b0, 32'h0, 32'h0, q, k, e, n);
    chk("ack_latency", n, 1);
    chk("stat_rst", q, 0);
    wb(0, 1'b0, 32'hC, 32'h0, q, k, e, n);
    chk("rdata_rst", q, 0);

    // address frame
    wb(0, 1'b1, 32'h4, 32'h0000_1E03, q, k, e, n);
    wb(0, 1'b1, 32'h8, 32'h0000_8000, q, k, e, n);
    wb(0, 1'b0, 32'h4, 32'h0, q, k, e, n);
    chk("addr_readback", q, 32'h0000_1E03);
    base = nr;
    cyc = 1'b1; stb = 2'b01; we = 1'b1; adr = 32'h0; dat = 32'h8000_0000;
    @(posedge clk);
    #1;
    t0 = cycles;
    chk("start_ack", {ack0, err0}, 2'b10);
    chk("first_bit", {oe0, mdo0}, 2'b11);
    cyc = 1'b0; stb = 2'b00; we = 1'b0;
    wait_done(0, q);
    chk("addr_stat", q, 32'h0);
    chk("addr_bits", hist[64:1], {32'hFFFF_FFFF, 2'b00, 2'b00, 5'h03, 5'h1E, 2'b10, 16'h8000});
    chk("addr_oe", ohist[64:1], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addr_end", {ohist[0], hist[0]}, 2'b01);
    chk("addr_rises", nr - base, 65);
    chk("addr_dur", tlast0 - t0, 2600);

    // write frame to port 1, with a rejected START and an ignored WDATA write mid-frame
    wb(0, 1'b1, 32'h8, 32'h0000_A5C3, q, k, e, n);
    base = nr;
    wb(0, 1'b1, 32'h0, 32'h8000_0005, q, k, e, n);
    t0 = tack;
    repeat (100) @(posedge clk);
    #1;
    chk("wr_sel_mid", sel0, 1);
    wb(0, 1'b1, 32'h0, 32'h8000_0003, q, k, e, n);
    chk("busy_start_err", {k, e}, 2'b01);
    chk("busy_err_latency", n, 1);
    wb(0, 1'b1, 32'h8, 32'h0000_1111, q, k, e, n);
    chk("busy_wdata_ack", {k, e}, 2'b10);
    wait_done(0, q);
    chk("wr_stat", q, 32'h5);
    chk("wr_bits", hist[64:1], {32'hFFFF_FFFF, 2'b00, 2'b01, 5'h03, 5'h1E, 2'b10, 16'hA5C3});
    chk("wr_oe", ohist[64:1], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_dur", tlast0 - t0, 2600);
    chk("wr_sel_hold", sel0, 1);
    wb(0, 1'b0, 32'h8, 32'h0, q, k, e, n);
    chk("wdata_kept", q, 32'h0000_A5C3);

    // read frame, PHY answers 0x1234
    phy = 1'b1;
    pdata = 16'h1234;
    base = nr;
    wb(0, 1'b1, 32'h0, 32'h8000_0003, q, k, e, n);
    wait_done(0, q);
    chk("rd_stat", q, 32'h3);
    chk("rd_hdr", hist[64:19], {32'hFFFF_FFFF, 2'b00, 2'b11, 5'h03, 5'h1E});
    chk("rd_oe", ohist[64:1], {{46{1'b1}}, 18'd0});
    chk("rd_sel", sel0, 0);
    wb(0, 1'b0, 32'hC, 32'h0, q, k, e, n);
    chk("rd_rdata", q, 32'h0001_1234);

    // read with no PHY: mdi stuck high
    phy = 1'b0;
    wb(0, 1'b1, 32'h0, 32'h8000_0003, q, k, e, n);
    wait_done(0, q);
    chk("noresp_stat", q, 32'h4000_0003);
    wb(0, 1'b0, 32'hC, 32'h0, q, k, e, n);
    chk("noresp_rdata", q, 32'h0001_FFFF);

    // reset in the middle of the header
    wb(0, 1'b1, 32'h0, 32'h8000_0000, q, k, e, n);
    repeat (1624) @(posedge clk);
    #1;
    chk("pre_rst_hdr", {oe0, mdc0}, 2'b11);
    #3 rst = 1'b1;
    #1;
    chk("rst_async", {oe0, mdc0}, 2'b00);
    #6 rst = 1'b0;
    wb(0, 1'b0, 32'h0, 32'h0, q, k, e, n);
    chk("rst_stat", q, 0);
    wb(0, 1'b0, 32'hC, 32'h0, q, k, e, n);
    chk("rst_rdata", q, 0);
    wb(0, 1'b1, 32'h4, 32'h0000_1E03, q, k, e, n);
    wb(0, 1'b1, 32'h8, 32'h0000_8000, q, k, e, n);
    base = nr;
    wb(0, 1'b1, 32'h0, 32'h8000_0000, q, k, e, n);
    t0 = tack;
    wait_done(0, q);
    chk("post_rst_bits", hist[64:1], {32'hFFFF_FFFF, 2'b00, 2'b00, 5'h03, 5'h1E, 2'b10, 16'h8000});
    chk("post_rst_dur", tlast0 - t0, 2600);

    // fast instance: CLK_DIV=2, no preamble
    wb(1, 1'b1, 32'h0, 32'h8000_0000, q, k, e, n);
    t0 = tack;
    chk("fast_ack", {k, e}, 2'b10);
    wait_done(1, q);
    chk("fast_stat", q, 32'h0);
    chk("fast_dur", tlast1 - t0, 132);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
